shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per serial frame; legal range 1..32.
REQ-002 Parameter IDLE_LEVEL, default 1'b0, level driven on sout when no frame is active.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high, sampled at posedge clk.
REQ-005 start  input  1  request to load din and begin a frame.
REQ-006 din  input  WIDTH  parallel word to serialize, MSB first.
REQ-007 busy  output  1  registered; high while a frame is in progress (SHIFT or DONE).
REQ-008 sout  output  1  registered serial data bit.
REQ-009 sout_valid  output  1  registered; high on each cycle sout carries a frame bit.
REQ-010 done  output  1  registered; single-cycle pulse after the last bit of a frame.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1 at edge k: the block SHALL capture din, drive sout=din[WIDTH-1] and sout_valid=1, load shreg=din<<1 and cnt=WIDTH-1, set busy=1, and enter SHIFT.
REQ-013 SHIFT with cnt!=0 at an edge: the block SHALL drive sout=shreg[WIDTH-1], shift shreg left by 1 with zero fill, and decrement cnt.
REQ-014 SHIFT with cnt==0 at an edge: the block SHALL drive sout_valid=0, sout=IDLE_LEVEL and done=1, and enter DONE.
REQ-015 DONE at the next edge: the block SHALL drive done=0 and busy=0, and enter IDLE unconditionally.
REQ-016 Timing: sout_valid SHALL be high for exactly WIDTH consecutive cycles, after edges k..k+WIDTH-1; done SHALL be high after edge k+WIDTH; busy SHALL be low after edge k+WIDTH+1.
REQ-017 start SHALL be ignored in SHIFT and DONE; it is neither queued nor able to alter din mid-frame.
REQ-018 din SHALL be sampled only at the capture edge; later changes to din SHALL NOT affect the frame.
REQ-019 If start is held high continuously, the next capture SHALL occur at edge k+WIDTH+2, giving exactly two non-valid cycles between frames.
REQ-020 WIDTH=1: cnt SHALL be loaded with 0, giving one valid cycle, then DONE.
REQ-021 cnt SHALL be max(1,$clog2(WIDTH)) bits wide; cnt SHALL never underflow.
REQ-022 Outside SHIFT, sout SHALL equal IDLE_LEVEL.

Reset
REQ-023 rst=1 at an edge SHALL force state=IDLE, busy=0, sout=IDLE_LEVEL, sout_valid=0, done=0, shreg=0 and cnt=0, taking priority over start.
REQ-024 Reset during SHIFT or DONE SHALL abort the frame with no done pulse; the first edge after rst falls SHALL honor start normally.
REQ-025 No output SHALL change asynchronously to clk.

Structure
REQ-026 The state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) SHALL live in the shared sequential package/include, together with the IDLE_LEVEL default.
REQ-027 shreg SHALL be built from one sub-module, dffe_sr: a WIDTH-parameterized register with enable and synchronous active-high reset.
REQ-028 The FSM, counter and output registers SHALL be coded in shift_seq itself; there is no combinational path from any input to any output.

Verification
REQ-029 WIDTH=8, start pulse with din=8'hA5 -> sout=1,0,1,0,0,1,0,1 with sout_valid high for 8 cycles, then done high for 1 cycle, then busy low.
REQ-030 Mid-frame start=1 with din=8'hFF during the 3rd bit -> frame continues as 8'hA5 and no second frame starts.
REQ-031 rst=1 at the 4th valid cycle -> after the next edge all outputs are at reset values with no done pulse; then start with 8'h3C -> 0,0,1,1,1,1,0,0.
REQ-032 rst=1 and start=1 at the same edge -> block stays IDLE with busy=0; no frame.
REQ-033 start held high with din=8'h81 -> repeated frames 1,0,0,0,0,0,0,1 separated by exactly 2 non-valid cycles.
REQ-034 WIDTH=1 with din=1'b1 -> one valid cycle with sout=1, done on the next cycle, and busy low 3 cycles after capture.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the serial shift sequencer: FSM encodings,
// parameter defaults and counter sizing.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int unsigned WIDTH_DEFAULT      = 8;
    localparam logic        IDLE_LEVEL_DEFAULT = 1'b0;

    // Bit counter width; at least one bit so WIDTH=1 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 32'd1) ? unsigned'($clog2(width)) : 32'd1;
    endfunction

endpackage

// File: rtl/dffe_sr.sv
// WIDTH-bit register with load enable and synchronous active-high clear.
module dffe_sr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Parallel-to-serial frame sequencer: loads a word on start and emits it
// MSB first, followed by a one-cycle done pulse and one idle cycle.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEFAULT,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               shreg_en;
    logic               busy_q, busy_d;
    logic               sout_q, sout_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    // Shift register holds the bits still to be sent after the current one.
    dffe_sr #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk (clk),
        .rst (rst),
        .en  (shreg_en),
        .d   (shreg_d),
        .q   (shreg_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        shreg_en = 1'b0;
        busy_d   = busy_q;
        sout_d   = IDLE_LEVEL;
        valid_d  = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d  = ST_SHIFT;
                    sout_d   = din[WIDTH-1];
                    valid_d  = 1'b1;
                    shreg_d  = din << 1;
                    shreg_en = 1'b1;
                    cnt_d    = CNT_W'(WIDTH - 1);
                    busy_d   = 1'b1;
                end
            end
            ST_SHIFT: begin
                busy_d = 1'b1;
                if (cnt_q != '0) begin
                    sout_d   = shreg_q[WIDTH-1];
                    valid_d  = 1'b1;
                    shreg_d  = shreg_q << 1;
                    shreg_en = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            sout_q  <= IDLE_LEVEL;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: an 8-bit instance (idle level 0) and a
// 1-bit instance (idle level 1) checked against a frame-age reference model.
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start1;
    logic [7:0] din8;
    logic [0:0] din1;
    logic       busy8, sout8, valid8, done8;
    logic       busy1, sout1, valid1, done1;
    logic [3:0] obs8, obs1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles elapsed since the last capture edge (-1 = none).
    int          age8 = -1;
    int          age1 = -1;
    logic [31:0] cap8 = '0;
    logic [31:0] cap1 = '0;

    shift_seq #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .din(din8),
        .busy(busy8), .sout(sout8), .sout_valid(valid8), .done(done8)
    );

    shift_seq #(.WIDTH(1), .IDLE_LEVEL(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .din(din1),
        .busy(busy1), .sout(sout1), .sout_valid(valid1), .done(done1)
    );

    always #5 clk = ~clk;

    assign obs8 = {busy8, sout8, valid8, done8};
    assign obs1 = {busy1, sout1, valid1, done1};

    // Expected {busy, sout, valid, done} for a frame of width w at a given age.
    function automatic logic [3:0] exp_obs(input int age, input logic [31:0] cap,
                                           input int w, input logic idle);
        if (age >= 0 && age < w) return {1'b1, cap[w-1-age], 1'b1, 1'b0};
        if (age == w)            return {1'b1, idle, 1'b0, 1'b1};
        return {1'b0, idle, 1'b0, 1'b0};
    endfunction

    // A new frame may start once w bits, the done cycle and one idle cycle elapsed.
    function automatic logic can_start(input int age, input int w);
        return (age < 0) || (age >= w + 1);
    endfunction

    task automatic tick(input logic r, input logic s8, input logic [7:0] d8,
                        input logic s1, input logic d1);
        rst = r; start8 = s8; din8 = d8; start1 = s1; din1 = d1;
        @(posedge clk);
        if (r) begin
            age8 = -1;
        end else if (can_start(age8, 8)) begin
            if (s8) cap8 = {24'd0, d8};
            age8 = s8 ? 0 : -1;
        end else begin
            age8 = age8 + 1;
        end
        if (r) begin
            age1 = -1;
        end else if (can_start(age1, 1)) begin
            if (s1) cap1 = {31'd0, d1};
            age1 = s1 ? 0 : -1;
        end else begin
            age1 = age1 + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n_tests++;
            if (obs8 !== 4'b0000) begin
                n_fail++; $display("FAIL reset_w8: got %b expected %b", obs8, 4'b0000);
            end
            n_tests++;
            if (obs1 !== 4'b0100) begin
                n_fail++; $display("FAIL reset_w1: got %b expected %b", obs1, 4'b0100);
            end
        end
        tick(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
        n_tests++;
        if (obs8 !== 4'b0000) begin
            n_fail++; $display("FAIL rst_start_w8: got %b expected %b", obs8, 4'b0000);
        end
        n_tests++;
        if (obs1 !== 4'b0100) begin
            n_fail++; $display("FAIL rst_start_w1: got %b expected %b", obs1, 4'b0100);
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++;
        if (obs8 !== 4'b0000) begin
            n_fail++; $display("FAIL rst_start_after: got %b expected %b", obs8, 4'b0000);
        end
    endtask

    task automatic test_frame_a5();
        logic [7:0] got = '0;
        int nv = 0, nd = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, c == 0, 8'hA5, 1'b0, 1'b0);
            if (valid8) begin got = {got[6:0], sout8}; nv++; end
            if (done8) nd++;
            n_tests++;
            if (obs8 !== exp_obs(age8, cap8, 8, 1'b0)) begin
                n_fail++; $display("FAIL a5_cycle%0d: got %b expected %b", c, obs8, exp_obs(age8, cap8, 8, 1'b0));
            end
        end
        n_tests++;
        if (got !== 8'hA5) begin
            n_fail++; $display("FAIL a5_bits: got %h expected %h", got, 8'hA5);
        end
        n_tests++;
        if (nv !== 8 || nd !== 1) begin
            n_fail++; $display("FAIL a5_counts: got valid=%0d done=%0d expected valid=8 done=1", nv, nd);
        end
    endtask

    task automatic test_midframe_start();
        logic [7:0] got = '0;
        int nv = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 0)      tick(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
            else if (c == 3) tick(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
            else             tick(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);
            if (valid8) begin got = {got[6:0], sout8}; nv++; end
            n_tests++;
            if (obs8 !== exp_obs(age8, cap8, 8, 1'b0)) begin
                n_fail++; $display("FAIL midstart_cycle%0d: got %b expected %b", c, obs8, exp_obs(age8, cap8, 8, 1'b0));
            end
        end
        n_tests++;
        if (got !== 8'hA5 || nv !== 8) begin
            n_fail++; $display("FAIL midstart_frame: got %h/%0d bits expected a5/8 bits", got, nv);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] got = '0;
        int nd = 0;
        for (int c = 0; c < 5; c++) begin
            tick(c == 4, c == 0, 8'hA5, 1'b0, 1'b0);
            if (done8) nd++;
        end
        n_tests++;
        if (obs8 !== 4'b0000 || nd !== 0) begin
            n_fail++; $display("FAIL abort_state: got %b done=%0d expected 0000 done=0", obs8, nd);
        end
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, c == 0, 8'h3C, 1'b0, 1'b0);
            if (valid8) got = {got[6:0], sout8};
            n_tests++;
            if (obs8 !== exp_obs(age8, cap8, 8, 1'b0)) begin
                n_fail++; $display("FAIL abort_3c_cycle%0d: got %b expected %b", c, obs8, exp_obs(age8, cap8, 8, 1'b0));
            end
        end
        n_tests++;
        if (got !== 8'h3C) begin
            n_fail++; $display("FAIL abort_3c_bits: got %h expected %h", got, 8'h3C);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got = '0;
        int run = 0, gap = -1, frames = 0;
        for (int c = 0; c < 42; c++) begin
            tick(1'b0, c < 30, 8'h81, 1'b0, 1'b0);
            n_tests++;
            if (obs8 !== exp_obs(age8, cap8, 8, 1'b0)) begin
                n_fail++; $display("FAIL b2b_cycle%0d: got %b expected %b", c, obs8, exp_obs(age8, cap8, 8, 1'b0));
            end
            if (valid8) begin
                if (run == 0 && gap >= 0) begin
                    n_tests++;
                    if (gap !== 2) begin
                        n_fail++; $display("FAIL b2b_gap: got %0d expected 2", gap);
                    end
                end
                got = {got[6:0], sout8};
                run++;
                if (run == 8) begin
                    n_tests++;
                    if (got !== 8'h81) begin
                        n_fail++; $display("FAIL b2b_bits: got %h expected %h", got, 8'h81);
                    end
                    frames++; run = 0; gap = 0;
                end
            end else if (gap >= 0) begin
                gap++;
            end
        end
        n_tests++;
        if (frames !== 3) begin
            n_fail++; $display("FAIL b2b_frames: got %0d expected 3", frames);
        end
    endtask

    task automatic test_width1();
        logic [3:0] want [0:3];
        want[0] = 4'b1110; want[1] = 4'b1101; want[2] = 4'b0100; want[3] = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 1'b0, 8'h00, c == 0, 1'b1);
            n_tests++;
            if (obs1 !== want[c]) begin
                n_fail++; $display("FAIL w1_cycle%0d: got %b expected %b", c, obs1, want[c]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 1'b0, 8'h00, c == 0, 1'b0);
            n_tests++;
            if (obs1 !== exp_obs(age1, cap1, 1, 1'b1)) begin
                n_fail++; $display("FAIL w1_zero_cycle%0d: got %b expected %b", c, obs1, exp_obs(age1, cap1, 1, 1'b1));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0, 8'($urandom),
                 $urandom_range(0, 1) == 1, 1'($urandom));
            n_tests++;
            if (obs8 !== exp_obs(age8, cap8, 8, 1'b0)) begin
                n_fail++; $display("FAIL rand_w8_cycle%0d: got %b expected %b", c, obs8, exp_obs(age8, cap8, 8, 1'b0));
            end
            n_tests++;
            if (obs1 !== exp_obs(age1, cap1, 1, 1'b1)) begin
                n_fail++; $display("FAIL rand_w1_cycle%0d: got %b expected %b", c, obs1, exp_obs(age1, cap1, 1, 1'b1));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0; din8 = '0; din1 = '0;
        test_reset();
        test_frame_a5();
        test_midframe_start();
        test_reset_abort();
        test_back_to_back();
        test_width1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
